// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver.
// Presents one byte per frame with parity/frame/overrun status.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] bd_rate,
  input  logic [1:0] par,
  input  logic       d_num,
  input  logic       s_num,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic [2:0] err,
  output logic       rdy,
  output logic       busy
);

  localparam int DIV0 = CLK_FREQ / (OVS * 1200);
  localparam int DIV1 = CLK_FREQ / (OVS * 2400);
  localparam int DIV2 = CLK_FREQ / (OVS * 4800);
  localparam int DIV3 = CLK_FREQ / (OVS * 9600);
  localparam int CW   = $clog2(DIV0 + 1);
  localparam int OW   = $clog2(OVS);

  localparam logic [OW-1:0] OS_MID = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] OS_END = OW'(OVS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [1:0]    r_warm;
  logic [2:0]    r_state;
  logic [CW-1:0] r_tick_cnt;
  logic [OW-1:0] r_os_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [1:0]    r_bd, r_par;
  logic          r_d8, r_s2;
  logic          r_perr, r_ferr;
  logic [7:0]    r_dout;
  logic [2:0]    r_err;
  logic          r_rdy;

  logic [CW-1:0] w_div_m1;
  logic [7:0]    w_data;
  logic          w_fall, w_tick, w_samp, w_last;

  // prev only reports a real 1 once the preset sync flops have flushed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b0;
      r_warm    <= 2'b00;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_warm    <= {r_warm[0], 1'b1};
      r_rx_prev <= r_rx_s2 & r_warm[1];
    end
  end

  always_comb begin
    w_div_m1 = CW'(DIV0 - 1);
    unique case (r_bd)
      2'd0: w_div_m1 = CW'(DIV0 - 1);
      2'd1: w_div_m1 = CW'(DIV1 - 1);
      2'd2: w_div_m1 = CW'(DIV2 - 1);
      2'd3: w_div_m1 = CW'(DIV3 - 1);
    endcase
  end

  assign w_fall = r_rx_prev & ~r_rx_s2;
  assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == w_div_m1);
  assign w_samp = w_tick && (r_os_cnt == OS_END);
  assign w_last = w_samp && ((r_state == S_STOP1 && !r_s2) ||
                             r_state == S_STOP2);
  assign w_data = r_d8 ? r_shift : {1'b0, r_shift[7:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_bd       <= '0;
      r_par      <= '0;
      r_d8       <= 1'b0;
      r_s2       <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_dout     <= '0;
      r_err      <= '0;
      r_rdy      <= 1'b0;
    end else begin
      if (rd_en)
        r_rdy <= 1'b0;
      if (r_state == S_IDLE || w_tick)
        r_tick_cnt <= '0;
      else
        r_tick_cnt <= r_tick_cnt + 1'b1;
      if (w_tick)
        r_os_cnt <= (r_os_cnt == OS_END) ? '0 : r_os_cnt + 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state   <= S_START;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_bd      <= bd_rate;
            r_par     <= par;
            r_d8      <= d_num;
            r_s2      <= s_num;
          end
        end
        S_START: begin
          if (w_tick && r_os_cnt == OS_MID) begin
            r_os_cnt <= '0;
            r_state  <= r_rx_s2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_samp) begin
            r_shift   <= {r_rx_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == (r_d8 ? 3'd7 : 3'd6))
              r_state <= (r_par == 2'd1 || r_par == 2'd2) ?
                         S_PARITY : S_STOP1;
          end
        end
        S_PARITY: begin
          if (w_samp) begin
            r_perr  <= (^w_data) ^ r_rx_s2 ^ (r_par == 2'd1);
            r_state <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (w_samp) begin
            r_ferr  <= r_ferr | ~r_rx_s2;
            r_state <= S_STOP2;
          end
        end
        S_STOP2: ;
        default: r_state <= S_IDLE;
      endcase

      // a same-cycle ack consumes the old byte, so no overrun
      if (w_last) begin
        r_dout  <= w_data;
        r_err   <= {r_rdy & ~rd_en, r_ferr | ~r_rx_s2, r_perr};
        r_rdy   <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end

  assign dout = r_dout;
  assign err  = r_err;
  assign rdy  = r_rdy;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against hand-computed results.
// Scaled clock gives divisors 32/16/8/4 for 1200..9600 baud.
module tb_uart_rx;

  localparam int CLK_FREQ = 614_400;

  logic       clk = 1'b0;
  logic       reset, rx, d_num, s_num, rd_en;
  logic [1:0] bd_rate, par;
  logic [7:0] dout;
  logic [2:0] err;
  logic       rdy, busy;
  int         n_checks = 0;
  int         n_pass = 0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .OVS(16)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .bd_rate(bd_rate), .par(par), .d_num(d_num), .s_num(s_num),
    .rd_en(rd_en), .dout(dout), .err(err), .rdy(rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  // entered on a negedge; each slot of bits (LSB first) held 16*div cycles
  task automatic send(input logic [11:0] bits, input int nslots,
                      input int div, input int ack_c, input int lim);
    int total;
    total = nslots * 16 * div;
    if (lim < total) total = lim;
    for (int c = 0; c < total; c++) begin
      rx    = bits[c / (16 * div)];
      rd_en = (c == ack_c);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] b, input logic [1:0] p,
                     input logic d, input logic s);
    bd_rate = b; par = p; d_num = d; s_num = s;
  endtask

  task automatic ack_pulse();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b0; rd_en = 1'b0;
    cfg(2'd3, 2'd0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({dout, err, rdy, busy} !== 13'd0)
      $display("FAIL reset_out: got %h expected %h", {dout, err, rdy, busy}, 13'd0);
    else n_pass++;
    repeat (100) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL low_out_of_reset busy: got %b expected 0", busy);
    else n_pass++;
    idle(10);
  endtask

  task automatic test_basic();
    cfg(2'd3, 2'd0, 1'b1, 1'b0);
    send({2'b11, 1'b1, 8'hA5, 1'b0}, 10, 4, -1, 1 << 30);
    n_checks++;
    if (dout !== 8'hA5) $display("FAIL t1_dout: got %h expected a5", dout);
    else n_pass++;
    n_checks++;
    if ({err, rdy, busy} !== 5'b000_1_0)
      $display("FAIL t1_flags: got %b expected 00010", {err, rdy, busy});
    else n_pass++;
    ack_pulse();
    n_checks++;
    if ({dout, err, rdy} !== {8'hA5, 3'b000, 1'b0})
      $display("FAIL t1_ack: got %h expected %h", {dout, err, rdy}, {8'hA5, 3'b000, 1'b0});
    else n_pass++;
  endtask

  task automatic test_parity();
    cfg(2'd2, 2'd1, 1'b0, 1'b0);
    send({2'b11, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 8, -1, 1 << 30);
    n_checks++;
    if ({dout, err, rdy} !== {8'h55, 3'b000, 1'b1})
      $display("FAIL t2_good: got %h expected %h", {dout, err, rdy}, {8'h55, 3'b000, 1'b1});
    else n_pass++;
    ack_pulse();
    send({2'b11, 1'b1, 1'b0, 7'h55, 1'b0}, 10, 8, -1, 1 << 30);
    n_checks++;
    if ({dout, err, rdy} !== {8'h55, 3'b001, 1'b1})
      $display("FAIL t2_bad: got %h expected %h", {dout, err, rdy}, {8'h55, 3'b001, 1'b1});
    else n_pass++;
  endtask

  task automatic test_frame_err();
    cfg(2'd0, 2'd2, 1'b1, 1'b1);
    ack_pulse();
    send({1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 12, 32, -1, 1 << 30);
    idle(8);
    n_checks++;
    if ({dout, err, rdy, busy} !== {8'h3C, 3'b010, 1'b1, 1'b0})
      $display("FAIL t3_frame: got %h expected %h", {dout, err, rdy, busy}, {8'h3C, 3'b010, 1'b1, 1'b0});
    else n_pass++;
  endtask

  task automatic test_glitch();
    cfg(2'd3, 2'd0, 1'b1, 1'b0);
    for (int c = 0; c < 64; c++) begin
      rx = (c < 16) ? 1'b0 : 1'b1;
      if (c == 24) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL t5_busy_early: got %b expected 1", busy);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({dout, err, rdy, busy} !== {8'h3C, 3'b010, 1'b1, 1'b0})
      $display("FAIL t5_glitch: got %h expected %h", {dout, err, rdy, busy}, {8'h3C, 3'b010, 1'b1, 1'b0});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cfg(2'd3, 2'd0, 1'b1, 1'b0);
    send({2'b11, 1'b1, 8'hFF, 1'b0}, 10, 4, -1, 192);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL t6_busy_mid: got %b expected 1", busy);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({dout, err, rdy, busy} !== 13'd0)
      $display("FAIL t6_reset: got %h expected %h", {dout, err, rdy, busy}, 13'd0);
    else n_pass++;
    idle(8);
    send({2'b11, 1'b1, 8'h81, 1'b0}, 10, 4, -1, 1 << 30);
    n_checks++;
    if ({dout, err, rdy, busy} !== {8'h81, 3'b000, 1'b1, 1'b0})
      $display("FAIL t6_after: got %h expected %h", {dout, err, rdy, busy}, {8'h81, 3'b000, 1'b1, 1'b0});
    else n_pass++;
  endtask

  // completion posedge is 3+8D+16D*9 after the start edge, D=16
  task automatic test_back_to_back();
    cfg(2'd1, 2'd0, 1'b1, 1'b0);
    ack_pulse();
    send({2'b11, 1'b1, 8'h12, 1'b0}, 10, 16, -1, 1 << 30);
    n_checks++;
    if ({dout, err, rdy} !== {8'h12, 3'b000, 1'b1})
      $display("FAIL t4_first: got %h expected %h", {dout, err, rdy}, {8'h12, 3'b000, 1'b1});
    else n_pass++;
    send({2'b11, 1'b1, 8'h34, 1'b0}, 10, 16, -1, 1 << 30);
    n_checks++;
    if ({dout, err, rdy} !== {8'h34, 3'b100, 1'b1})
      $display("FAIL t4_overrun: got %h expected %h", {dout, err, rdy}, {8'h34, 3'b100, 1'b1});
    else n_pass++;
    send({2'b11, 1'b1, 8'h12, 1'b0}, 10, 16, -1, 1 << 30);
    send({2'b11, 1'b1, 8'h34, 1'b0}, 10, 16, 2434, 1 << 30);
    n_checks++;
    if ({dout, err, rdy} !== {8'h34, 3'b000, 1'b1})
      $display("FAIL t4_ack_same: got %h expected %h", {dout, err, rdy}, {8'h34, 3'b000, 1'b1});
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver side of the team's UART.
- Deserialises an asynchronous frame on `rx` and presents the byte on `dout` with parity, frame and overrun status on `err`.
- Uses the same configuration encoding as the UART top (`bd_rate`, `par`, `d_num`, `s_num`) so it pairs directly with the transmitter.
- Samples at 16x baud and takes the data value at mid-bit.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- OVS, 16, oversample ticks per bit.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  serial line; idle high; asynchronous to clk.
- bd_rate  in  2  baud select: 0=1200, 1=2400, 2=4800, 3=9600.
- par  in  2  parity: 0=none, 1=odd, 2=even, 3=none.
- d_num  in  1  data bits: 0=7, 1=8.
- s_num  in  1  stop bits: 0=1, 1=2.
- rd_en  in  1  consumer acknowledge; clears rdy.
- dout  out  8  received data, LSB-first assembled; bit7=0 in 7-bit mode.
- err  out  3  [0]=parity error, [1]=frame error, [2]=overrun.
- rdy  out  1  data-available flag.
- busy  out  1  high from start-bit detection to frame end.

Behaviour:
- Reset (synchronous, active-high, one clk):
  - dout=0, err=0, rdy=0, busy=0.
  - FSM=IDLE, counters=0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame aborts the frame with no output update.
- Input sync: `rx` passes through 2 flops. All logic uses the synced signal. This adds 2-cycle latency.
- Tick generator:
  - DIV = CLK_FREQ/(OVS*baud), integer division.
  - Counter runs 0..DIV-1 and emits a 1-cycle tick at wrap.
  - Counter is cleared on IDLE→START.
  - At 50 MHz: DIV = 2604, 1302, 651, 325.
- Config latching: bd_rate, par, d_num, s_num are captured at IDLE→START. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: wait for a falling edge on synced rx (previous=1, current=0), then go to START and set busy=1. A line held low out of reset is not a start.
  - START: at tick 7 (mid-bit), rx=0 → DATA; rx=1 → false start, go to IDLE with no flags changed.
  - DATA: sample every 16 ticks, shift LSB-first. After 7 or 8 bits (per d_num): go to PARITY if par is 1 or 2, else STOP1.
  - PARITY: sample one bit.
    - Odd mode: error if XOR(data bits, parity bit) != 1.
    - Even mode: error if that XOR != 0.
    - Only d_num data bits count.
  - STOP1: sample. If s_num=1 go to STOP2; else complete the frame.
  - STOP2: sample, then complete the frame.
  - Any sampled stop bit = 0 sets the frame error.
- Frame completion, on the clk of the last stop-bit mid-sample:
  - dout ← data; 7-bit mode zero-extends.
  - err[0] ← parity error; err[1] ← frame error.
  - err[2] ← (rdy was 1 and rd_en=0 on this cycle).
  - rdy ← 1; busy ← 0; FSM → IDLE.
  - On a frame error the data is still written.
- rd_en handling:
  - rd_en=1 with no completion: rdy ← 0. dout and err are held.
  - rd_en=1 on the same cycle as completion: the old data counts as consumed, so no overrun, and rdy stays 1 with the new data.
- Overrun: the new data overwrites dout. err is held until the next completion.
- Back-to-back frames: return to IDLE at mid-stop-bit, so a start edge is detected for a frame that follows with zero idle gap.

Test Plan:
1. 9600, par=0, d_num=1, s_num=0; send 0xA5 → at mid-stop: dout=0xA5, err=000, rdy=1, busy=0. Then rd_en pulse → rdy=0.
2. 4800, par=1 (odd), d_num=0; send 7-bit 0x55 with correct parity 1 → dout=0x55, err=000. Resend with parity 0 → err=001, dout=0x55.
3. 1200, par=2, s_num=1; send 0x3C with second stop bit driven 0 → err[1]=1, dout=0x3C, rdy=1.
4. Two back-to-back 2400 frames 0x12 then 0x34, no rd_en → after the second: dout=0x34, err[2]=1. Repeat with rd_en asserted on the completion cycle → err[2]=0, rdy=1.
5. Glitch: rx low for 4 ticks then high → FSM returns to IDLE; rdy, dout, err unchanged; busy drops after the tick-7 check.
6. Assert reset during the DATA state of a 0xFF frame → next cycle dout=0, err=0, rdy=0, busy=0. Then a following valid 0x81 frame is received correctly.
